// File: rtl/prog_pulse_generator.sv
// Programmable period pulser: one-clock max_tick every (max_count+1)*(prescale+1) clocks in RUN.
// Outputs are combinational from registers; no backpressure, start/stop act on the next edge.
module prog_pulse_generator #(
    parameter int WIDTH      = 16,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  one_shot,
    input  logic [WIDTH-1:0]      max_count,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  max_tick,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [WIDTH-1:0]      max_lat_q, max_lat_d;
    logic [PRESCALE_W-1:0] pre_lat_q, pre_lat_d;
    logic                  mode_q, mode_d;
    logic                  done_q, done_d;

    logic strobe;
    logic terminal;

    assign strobe   = (pre_q == pre_lat_q);
    assign terminal = strobe && (count_q == max_lat_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            pre_q     <= '0;
            max_lat_q <= '0;
            pre_lat_q <= '0;
            mode_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pre_q     <= pre_d;
            max_lat_q <= max_lat_d;
            pre_lat_q <= pre_lat_d;
            mode_q    <= mode_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pre_d     = pre_q;
        max_lat_d = max_lat_q;
        pre_lat_d = pre_lat_q;
        mode_d    = mode_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                count_d = '0;
                pre_d   = '0;
                if (start && !stop) begin
                    max_lat_d = max_count;
                    pre_lat_d = prescale;
                    mode_d    = one_shot;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                    count_d = '0;
                    pre_d   = '0;
                end else begin
                    pre_d = strobe ? '0 : pre_q + 1'b1;
                    if (strobe) begin
                        count_d = terminal ? '0 : count_q + 1'b1;
                    end
                    // Limits only change at a period boundary so a period is never cut short.
                    if (terminal) begin
                        if (mode_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            max_lat_d = max_count;
                            pre_lat_d = prescale;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == RUN);
        max_tick = busy && terminal;
        count    = count_q;
        done     = done_q;
    end

endmodule

// File: tb/tb_prog_pulse_generator.sv
// Bench for prog_pulse_generator: a 16-bit and a 4-bit instance driven in parallel against a phase-based model.
module tb_prog_pulse_generator;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, start, stop, one_shot;
    logic [15:0] max_count;
    logic [7:0]  prescale;

    logic [15:0] count0;
    logic        tick0, busy0, done0;
    logic [3:0]  count1;
    logic        tick1, busy1, done1;

    prog_pulse_generator #(.WIDTH(16), .PRESCALE_W(8)) dut0 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .one_shot(one_shot),
        .max_count(max_count), .prescale(prescale),
        .count(count0), .max_tick(tick0), .busy(busy0), .done(done0)
    );

    prog_pulse_generator #(.WIDTH(4), .PRESCALE_W(8)) dut1 (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .one_shot(one_shot),
        .max_count(max_count[3:0]), .prescale(prescale),
        .count(count1), .max_tick(tick1), .busy(busy1), .done(done1)
    );

    typedef struct {
        int c;
        bit tk;
        bit b;
        bit d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: t is the clock index within the current period; count is derived by division.
    bit m_run[2];
    int m_m[2];
    int m_p[2];
    int m_t[2];
    bit m_mode[2];
    bit m_done[2];
    int mask[2];

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_tick(input int i);
        return m_run[i] && (m_t[i] == (m_m[i] + 1) * (m_p[i] + 1) - 1);
    endfunction

    function automatic exp_t predict(input int i);
        exp_t e;
        e.c  = m_run[i] ? (m_t[i] / (m_p[i] + 1)) : 0;
        e.tk = model_tick(i);
        e.b  = m_run[i];
        e.d  = m_done[i];
        return e;
    endfunction

    task automatic advance(input int i);
        bit tk;
        bit dn;
        tk = model_tick(i);
        dn = 1'b0;
        if (reset) begin
            m_run[i] = 0; m_m[i] = 0; m_p[i] = 0; m_t[i] = 0; m_mode[i] = 0;
        end else if (!m_run[i]) begin
            if (start && !stop) begin
                m_run[i]  = 1;
                m_m[i]    = int'(max_count) & mask[i];
                m_p[i]    = int'(prescale);
                m_mode[i] = one_shot;
                m_t[i]    = 0;
            end
        end else if (stop) begin
            m_run[i] = 0;
            m_t[i]   = 0;
        end else if (tk) begin
            m_t[i] = 0;
            if (m_mode[i]) begin
                m_run[i] = 0;
                dn       = 1'b1;
            end else begin
                m_m[i] = int'(max_count) & mask[i];
                m_p[i] = int'(prescale);
            end
        end else begin
            m_t[i] = m_t[i] + 1;
        end
        m_done[i] = dn;
    endtask

    // Predictions for the state after the coming edge are queued, then popped and compared after it.
    task automatic step();
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            advance(i);
            sb.push_back(predict(i));
        end
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("u16_count", int'(count0), e.c);
        check("u16_tick",  int'(tick0),  int'(e.tk));
        check("u16_busy",  int'(busy0),  int'(e.b));
        check("u16_done",  int'(done0),  int'(e.d));
        e = sb.pop_front();
        check("u4_count", int'(count1), e.c);
        check("u4_tick",  int'(tick1),  int'(e.tk));
        check("u4_busy",  int'(busy1),  int'(e.b));
        check("u4_done",  int'(done1),  int'(e.d));
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic launch(input int mc, input int ps, input bit os);
        max_count = 16'(mc);
        prescale  = 8'(ps);
        one_shot  = os;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic halt();
        stop = 1'b1;
        step();
        stop = 1'b0;
        step();
    endtask

    int ticks_seen;

    initial begin
        mask[0] = 32'hFFFF;
        mask[1] = 32'hF;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 0; m_m[i] = 0; m_p[i] = 0; m_t[i] = 0; m_mode[i] = 0; m_done[i] = 0;
        end
        reset = 1'b1; start = 1'b0; stop = 1'b0; one_shot = 1'b0;
        max_count = 16'd0; prescale = 8'd0;
        steps(2);
        reset = 1'b0;
        steps(2);

        // Continuous, no prescale: ticks in RUN clocks 4, 8, 12.
        launch(3, 0, 1'b0);
        ticks_seen = 0;
        for (int k = 0; k < 13; k++) begin
            step();
            if (tick0) ticks_seen++;
        end
        check("cont_tick_count", ticks_seen, 3);
        halt();

        // Prescaled one-shot: single tick in RUN clock 6, then done.
        launch(2, 1, 1'b1);
        steps(10);

        // Shadowing: max_count changed during the first period.
        launch(4, 0, 1'b0);
        step();
        max_count = 16'd1;
        steps(10);
        halt();

        // stop together with start at count=2.
        launch(5, 0, 1'b0);
        steps(2);
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        step();
        // start blocked by stop while idle.
        stop = 1'b1; start = 1'b1;
        steps(2);
        stop = 1'b0; start = 1'b0;
        step();
        // stop on the terminal cycle.
        launch(2, 0, 1'b1);
        steps(2);
        check("term_tick", int'(tick0), 1);
        stop = 1'b1;
        step();
        stop = 1'b0;
        steps(2);

        // Reset mid-run at count=3, then restart.
        launch(5, 0, 1'b0);
        steps(3);
        check("pre_reset_count", int'(count0), 3);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        launch(5, 0, 1'b0);
        steps(8);
        halt();

        // max_count=0, prescale=0: tick every RUN clock.
        launch(0, 0, 1'b0);
        steps(5);
        halt();

        // All-ones limit on the 4-bit instance.
        launch(15, 0, 1'b0);
        steps(40);
        halt();

        // start held high in one-shot mode re-arms after a one-clock idle gap.
        max_count = 16'd1; prescale = 8'd0; one_shot = 1'b1; start = 1'b1;
        steps(10);
        start = 1'b0;
        steps(4);

        // start in RUN is ignored, prescaler larger than the count.
        launch(1, 3, 1'b0);
        steps(3);
        start = 1'b1; max_count = 16'd7;
        steps(3);
        start = 1'b0;
        steps(6);
        halt();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
